// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pkg
// Description : Shared types, default widths and the window-compare helper
//               for the per-sprite raster engine.
//               SPRITE_MIRROR_EN adds the mirror bit to the sprite config.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

  localparam int DEF_COORD_WIDTH = 11;
  localparam int DEF_ADD_WIDTH   = 16;

  typedef logic [DEF_COORD_WIDTH-1:0] coord_t;
  typedef logic [1:0]                 layer_t;

  // Staging and active sprite configuration share this layout.
  typedef struct packed {
    coord_t                   x;
    coord_t                   y;
    coord_t                   w;
    coord_t                   h;
    logic [DEF_ADD_WIDTH-1:0] base;
    layer_t                   layer;
    logic                     enable;
`ifdef SPRITE_MIRROR_EN
    logic                     mirror;
`endif
  } sprite_cfg_t;

  // True when pos lies in [start, start+size). One extra bit keeps the end
  // bound from wrapping, so sprites hanging off the raster edge clip cleanly.
  function automatic logic in_window(coord_t pos, coord_t start, coord_t size);
    logic [DEF_COORD_WIDTH:0] p;
    logic [DEF_COORD_WIDTH:0] s;
    logic [DEF_COORD_WIDTH:0] e;
    p = {1'b0, pos};
    s = {1'b0, start};
    e = s + {1'b0, size};
    return (p >= s) && (p < e);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : sprite_addr_gen
// Description : Sprite-RAM address generator. Owns the column counter, the
//               row offset and the registered texel address.
//               SPRITE_MIRROR_EN adds the horizontal flip of the column.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int ADD_WIDTH   = DEF_ADD_WIDTH,
  parameter int COORD_WIDTH = DEF_COORD_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_clr,
  input  logic                   line_adv,
  input  logic                   row_hit,
  input  logic                   pix_hit,
  input  logic [COORD_WIDTH-1:0] w,
  input  logic [ADD_WIDTH-1:0]   base,
`ifdef SPRITE_MIRROR_EN
  input  logic                   mirror,
`endif
  output logic [ADD_WIDTH-1:0]   address
);

  logic [COORD_WIDTH-1:0] col;
  logic [COORD_WIDTH-1:0] col_sel;
  logic [ADD_WIDTH-1:0]   row_off;

  // Texel column within the sprite row; col < w whenever a pixel hits.
  always_comb begin
`ifdef SPRITE_MIRROR_EN
    col_sel = mirror ? (w - COORD_WIDTH'(1) - col) : col;
`else
    col_sel = col;
`endif
  end

  // Column/row bookkeeping and the address register; the top resolves strobe priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      col     <= '0;
      row_off <= '0;
      address <= '0;
    end else if (frame_clr) begin
      col     <= '0;
      row_off <= '0;
    end else if (line_adv) begin
      col <= '0;
      if (row_hit) begin
        row_off <= row_off + ADD_WIDTH'(w);
      end
    end else if (pix_hit) begin
      address <= base + row_off + ADD_WIDTH'(col_sel);
      col     <= col + COORD_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_blob.sv
`default_nettype none
// ============================================================================
// Module      : sprite_blob
// Description : Per-sprite raster engine feeding one pixel-arbiter slot.
//               Tracks raster position, tests sprite coverage and drives
//               request/address/layer. Config is double-buffered and only
//               becomes active at frame start.
//               SPRITE_MIRROR_EN adds cfg_mirror (horizontal flip).
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_blob
  import sprite_pkg::*;
#(
  parameter int ADD_WIDTH   = DEF_ADD_WIDTH,
  parameter int COORD_WIDTH = DEF_COORD_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   line_start,
  input  logic                   pixel_en,
  input  logic                   cfg_wr,
  input  logic [COORD_WIDTH-1:0] cfg_x,
  input  logic [COORD_WIDTH-1:0] cfg_y,
  input  logic [COORD_WIDTH-1:0] cfg_w,
  input  logic [COORD_WIDTH-1:0] cfg_h,
  input  logic [ADD_WIDTH-1:0]   cfg_base,
  input  logic [1:0]             cfg_layer,
  input  logic                   cfg_enable,
`ifdef SPRITE_MIRROR_EN
  input  logic                   cfg_mirror,
`endif
  output logic                   request,
  output logic [ADD_WIDTH-1:0]   address,
  output logic [1:0]             layer
);

  // The config struct is sized by the package defaults; keep the
  // parameters at those values.
  sprite_cfg_t            cfg_in;
  sprite_cfg_t            stage;
  sprite_cfg_t            active;

  logic [COORD_WIDTH-1:0] hcnt;
  logic [COORD_WIDTH-1:0] vcnt;
  logic [COORD_WIDTH-1:0] hcnt_next;
  logic [COORD_WIDTH-1:0] vcnt_next;
  logic                   in_rows;
  logic                   hit;
  logic                   line_go;
  logic                   pix_go;

  // Pack the configuration inputs into the staging layout.
  always_comb begin
    cfg_in        = '0;
    cfg_in.x      = cfg_x;
    cfg_in.y      = cfg_y;
    cfg_in.w      = cfg_w;
    cfg_in.h      = cfg_h;
    cfg_in.base   = cfg_base;
    cfg_in.layer  = cfg_layer;
    cfg_in.enable = cfg_enable;
`ifdef SPRITE_MIRROR_EN
    cfg_in.mirror = cfg_mirror;
`endif
  end

  // Saturating raster counters, coverage test and priority-qualified strobes.
  always_comb begin
    hcnt_next = (&hcnt) ? hcnt : hcnt + COORD_WIDTH'(1);
    vcnt_next = (&vcnt) ? vcnt : vcnt + COORD_WIDTH'(1);
    hit       = active.enable & in_rows & in_window(hcnt, active.x, active.w);
    line_go   = line_start & ~frame_start;
    pix_go    = pixel_en & ~frame_start & ~line_start & hit;
  end

  // Config buffers, raster position, row coverage and the request register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage   <= '0;
      active  <= '0;
      hcnt    <= '0;
      vcnt    <= '0;
      in_rows <= 1'b0;
      request <= 1'b0;
    end else begin
      // A write coinciding with frame_start lands in staging for the next frame.
      if (cfg_wr) begin
        stage <= cfg_in;
      end
      if (frame_start) begin
        active  <= stage;
        hcnt    <= '0;
        vcnt    <= '0;
        in_rows <= in_window('0, stage.y, stage.h);
        request <= 1'b0;
      end else if (line_start) begin
        hcnt    <= '0;
        vcnt    <= vcnt_next;
        in_rows <= in_window(vcnt_next, active.y, active.h);
        request <= 1'b0;
      end else if (pixel_en) begin
        request <= hit;
        hcnt    <= hcnt_next;
      end
    end
  end

  assign layer = active.layer;

  sprite_addr_gen #(
    .ADD_WIDTH   (ADD_WIDTH),
    .COORD_WIDTH (COORD_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .frame_clr (frame_start),
    .line_adv  (line_go),
    .row_hit   (in_rows),
    .pix_hit   (pix_go),
    .w         (active.w),
    .base      (active.base),
`ifdef SPRITE_MIRROR_EN
    .mirror    (active.mirror),
`endif
    .address   (address)
  );

endmodule
`default_nettype wire

// File: tb/tb_sprite_blob.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_blob
// Description : Directed self-checking bench for sprite_blob.
//               SPRITE_MIRROR_EN enables the mirror scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_blob;

  localparam int AW = 16;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          line_start = 1'b0;
  logic          pixel_en = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [CW-1:0] cfg_x = '0;
  logic [CW-1:0] cfg_y = '0;
  logic [CW-1:0] cfg_w = '0;
  logic [CW-1:0] cfg_h = '0;
  logic [AW-1:0] cfg_base = '0;
  logic [1:0]    cfg_layer = '0;
  logic          cfg_enable = 1'b0;
`ifdef SPRITE_MIRROR_EN
  logic          cfg_mirror = 1'b0;
`endif
  logic          request;
  logic [AW-1:0] address;
  logic [1:0]    layer;

  int            checks = 0;
  int            errors = 0;
  logic          pr;
  logic [AW-1:0] pa;

  always #5 clk = ~clk;

  sprite_blob #(
    .ADD_WIDTH   (AW),
    .COORD_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .line_start  (line_start),
    .pixel_en    (pixel_en),
    .cfg_wr      (cfg_wr),
    .cfg_x       (cfg_x),
    .cfg_y       (cfg_y),
    .cfg_w       (cfg_w),
    .cfg_h       (cfg_h),
    .cfg_base    (cfg_base),
    .cfg_layer   (cfg_layer),
    .cfg_enable  (cfg_enable),
`ifdef SPRITE_MIRROR_EN
    .cfg_mirror  (cfg_mirror),
`endif
    .request     (request),
    .address     (address),
    .layer       (layer)
  );

  // Stimulus helpers: all called at a negedge, inputs held across one posedge.
  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic do_line();
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  // One pixel strobe with arbiter spacing; outputs captured one cycle later.
  task automatic do_pixel();
    pixel_en = 1'b1;
    @(negedge clk);
    pixel_en = 1'b0;
    pr = request;
    pa = address;
    repeat (3) @(negedge clk);
  endtask

  task automatic write_cfg(input logic [CW-1:0] x, input logic [CW-1:0] y,
                           input logic [CW-1:0] w, input logic [CW-1:0] h,
                           input logic [AW-1:0] base, input logic [1:0] lay,
                           input logic en);
    cfg_x = x; cfg_y = y; cfg_w = w; cfg_h = h;
    cfg_base = base; cfg_layer = lay; cfg_enable = en;
    cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (request !== 1'b0) begin errors++; $display("FAIL reset_request got %0b exp 0", request); end
    checks++; if (address !== 16'h0) begin errors++; $display("FAIL reset_address got %h exp 0000", address); end
    checks++; if (layer !== 2'd0) begin errors++; $display("FAIL reset_layer got %0d exp 0", layer); end
    do_pixel();
    checks++; if (pr !== 1'b0) begin errors++; $display("FAIL reset_silent got %0b exp 0", pr); end
  endtask

  task automatic test_basic();
    logic          exp;
    logic [AW-1:0] ea;
    write_cfg(11'd10, 11'd5, 11'd4, 11'd2, 16'h0100, 2'd2, 1'b1);
    pulse_frame();
    checks++; if (layer !== 2'd2) begin errors++; $display("FAIL basic_layer got %0d exp 2", layer); end
    for (int r = 0; r < 8; r++) begin
      if (r > 0) do_line();
      for (int c = 0; c < 16; c++) begin
        do_pixel();
        exp = (r >= 5 && r <= 6 && c >= 10 && c <= 13);
        checks++;
        if (pr !== exp) begin errors++; $display("FAIL basic_req r=%0d c=%0d got %0b exp %0b", r, c, pr, exp); end
        if (exp) begin
          ea = AW'(32'h100 + (r - 5) * 4 + (c - 10));
          checks++;
          if (pa !== ea) begin errors++; $display("FAIL basic_addr r=%0d c=%0d got %h exp %h", r, c, pa, ea); end
        end
      end
    end
  endtask

  // Pass 0: mid-frame write of x=20 must not move the current frame (x=10).
  // Pass 1: write of x=30 coincident with frame_start; frame uses x=20.
  // Pass 2: following frame uses x=30.
  task automatic test_double_buffer();
    logic          exp;
    logic [AW-1:0] ea;
    int            xs;
    for (int p = 0; p < 3; p++) begin
      if (p == 0) begin
        pulse_frame();
        write_cfg(11'd20, 11'd5, 11'd4, 11'd2, 16'h0100, 2'd2, 1'b1);
        xs = 10;
      end else if (p == 1) begin
        cfg_x = 11'd30;
        cfg_wr = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
        frame_start = 1'b0;
        xs = 20;
      end else begin
        pulse_frame();
        xs = 30;
      end
      repeat (5) do_line();
      for (int c = 0; c < 36; c++) begin
        do_pixel();
        exp = (c >= xs && c < xs + 4);
        checks++;
        if (pr !== exp) begin errors++; $display("FAIL dbuf_req pass=%0d c=%0d got %0b exp %0b", p, c, pr, exp); end
        if (exp) begin
          ea = AW'(32'h100 + (c - xs));
          checks++;
          if (pa !== ea) begin errors++; $display("FAIL dbuf_addr pass=%0d c=%0d got %h exp %h", p, c, pa, ea); end
        end
      end
    end
  endtask

  task automatic test_clip();
    logic          exp;
    logic [AW-1:0] ea;
    write_cfg(11'd2046, 11'd0, 11'd8, 11'd1, 16'h0200, 2'd1, 1'b1);
    pulse_frame();
    checks++; if (layer !== 2'd1) begin errors++; $display("FAIL clip_layer got %0d exp 1", layer); end
    for (int c = 0; c < 2048; c++) begin
      do_pixel();
      exp = (c >= 2046);
      checks++;
      if (pr !== exp) begin errors++; $display("FAIL clip_req c=%0d got %0b exp %0b", c, pr, exp); end
      if (exp) begin
        ea = AW'(32'h200 + (c - 2046));
        checks++;
        if (pa !== ea) begin errors++; $display("FAIL clip_addr c=%0d got %h exp %h", c, pa, ea); end
      end
    end
  endtask

  task automatic test_degenerate();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) write_cfg(11'd10, 11'd5, 11'd0, 11'd2, 16'h0100, 2'd2, 1'b1);
      else        write_cfg(11'd10, 11'd5, 11'd4, 11'd2, 16'h0100, 2'd2, 1'b0);
      pulse_frame();
      for (int r = 0; r < 8; r++) begin
        if (r > 0) do_line();
        for (int c = 0; c < 16; c++) begin
          do_pixel();
          checks++;
          if (pr !== 1'b0) begin errors++; $display("FAIL degen_req k=%0d r=%0d c=%0d got %0b exp 0", k, r, c, pr); end
        end
      end
    end
  endtask

  task automatic test_priority();
    write_cfg(11'd0, 11'd0, 11'd4, 11'd4, 16'h0040, 2'd3, 1'b1);
    pulse_frame();
    do_pixel();
    do_pixel();
    do_line();
    do_pixel();
    checks++; if (pr !== 1'b1) begin errors++; $display("FAIL prio_row1_req got %0b exp 1", pr); end
    checks++; if (pa !== 16'h0044) begin errors++; $display("FAIL prio_row1_addr got %h exp 0044", pa); end
    do_line();
    checks++; if (request !== 1'b0) begin errors++; $display("FAIL prio_line_clear got %0b exp 0", request); end
    do_pixel();
    checks++; if (pa !== 16'h0048) begin errors++; $display("FAIL prio_row2_addr got %h exp 0048", pa); end
    frame_start = 1'b1;
    line_start = 1'b1;
    pixel_en = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    line_start = 1'b0;
    pixel_en = 1'b0;
    checks++; if (request !== 1'b0) begin errors++; $display("FAIL prio_coincident_req got %0b exp 0", request); end
    do_pixel();
    checks++; if (pr !== 1'b1) begin errors++; $display("FAIL prio_origin_req got %0b exp 1", pr); end
    checks++; if (pa !== 16'h0040) begin errors++; $display("FAIL prio_origin_addr got %h exp 0040", pa); end
    do_pixel();
    checks++; if (pa !== 16'h0041) begin errors++; $display("FAIL prio_next_addr got %h exp 0041", pa); end
  endtask

`ifdef SPRITE_MIRROR_EN
  task automatic test_mirror();
    logic          exp;
    logic [AW-1:0] ea;
    cfg_mirror = 1'b1;
    write_cfg(11'd10, 11'd5, 11'd4, 11'd2, 16'h0100, 2'd2, 1'b1);
    pulse_frame();
    for (int r = 0; r < 7; r++) begin
      if (r > 0) do_line();
      for (int c = 0; c < 16; c++) begin
        do_pixel();
        exp = (r >= 5 && c >= 10 && c <= 13);
        checks++;
        if (pr !== exp) begin errors++; $display("FAIL mirror_req r=%0d c=%0d got %0b exp %0b", r, c, pr, exp); end
        if (exp) begin
          ea = AW'(32'h100 + (r - 5) * 4 + (3 - (c - 10)));
          checks++;
          if (pa !== ea) begin errors++; $display("FAIL mirror_addr r=%0d c=%0d got %h exp %h", r, c, pa, ea); end
        end
      end
    end
    cfg_mirror = 1'b0;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_double_buffer();
    test_clip();
    test_degenerate();
    test_priority();
`ifdef SPRITE_MIRROR_EN
    test_mirror();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
